// File: rtl/ula_seq_ctrl_if.sv
// Operand/result bundle for the ULA sequencer: request side (start/op/a/b)
// and the registered result side (busy/done/result/flags).
interface ula_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               zf;
  logic               cf;
  logic               vf;
  logic               dz;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zf, cf, vf, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zf, cf, vf, dz
  );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Multi-cycle ULA sequencer: single-cycle logic/arithmetic ops, shift-add
// multiply and restoring divide over a shared 2*WIDTH accumulator.
module ula_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           clr,
  ula_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               zf_reg, cf_reg, vf_reg, dz_reg;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] exec_result;
  logic               exec_cf, exec_vf, exec_dz;

  // start is honoured in DONE as well, giving back-to-back operation
  assign accept    = bus.start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state_next = S_MUL;
          end else if (bus.op == OP_DIV && bus.b != '0) begin
            state_next = S_DIV;
          end else begin
            state_next = S_EXEC;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_EXEC: state_next = S_DONE;
      S_MUL, S_DIV: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff = {1'b0, a_reg} - {1'b0, b_reg};

  // Multiplier sits in the low half; carry out of the add shifts into the MSB
  assign mul_upper = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
  assign mul_next  = {mul_upper, acc_reg[WIDTH-1:1]};

  // Partial remainder is below b, so the shifted value fits in WIDTH+1 bits
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, b_reg};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  always_comb begin
    exec_result = '0;
    exec_cf     = 1'b0;
    exec_vf     = 1'b0;
    exec_dz     = 1'b0;
    case (op_reg)
      OP_ADD: begin
        exec_result = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        exec_cf     = sum[WIDTH];
        exec_vf     = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        exec_result = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        exec_cf     = diff[WIDTH];
        exec_vf     = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: exec_result = {{WIDTH{1'b0}}, a_reg & b_reg};
      OP_OR:  exec_result = {{WIDTH{1'b0}}, a_reg | b_reg};
      OP_XOR: exec_result = {{WIDTH{1'b0}}, a_reg ^ b_reg};
      OP_NOT: exec_result = {{WIDTH{1'b0}}, ~a_reg};
      OP_DIV: begin
        // only reaches EXEC when the divisor is zero
        exec_result = {a_reg, {WIDTH{1'b1}}};
        exec_dz     = 1'b1;
      end
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      zf_reg     <= 1'b0;
      cf_reg     <= 1'b0;
      vf_reg     <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      if (accept) begin
        op_reg  <= bus.op;
        a_reg   <= bus.a;
        b_reg   <= bus.b;
        cnt_reg <= '0;
        acc_reg <= (bus.op == OP_MUL) ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{1'b0}}, bus.a};
      end
      case (state_reg)
        S_EXEC: begin
          result_reg <= exec_result;
          zf_reg     <= (exec_result == '0);
          cf_reg     <= exec_cf;
          vf_reg     <= exec_vf;
          dz_reg     <= exec_dz;
        end
        S_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= last_iter ? '0 : cnt_reg + 1'b1;
          if (last_iter) begin
            result_reg <= mul_next;
            zf_reg     <= (mul_next == '0);
            cf_reg     <= 1'b0;
            vf_reg     <= 1'b0;
            dz_reg     <= 1'b0;
          end
        end
        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= last_iter ? '0 : cnt_reg + 1'b1;
          if (last_iter) begin
            result_reg <= div_next;
            zf_reg     <= (div_next == '0);
            cf_reg     <= 1'b0;
            vf_reg     <= 1'b0;
            dz_reg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg == S_EXEC) || (state_reg == S_MUL) || (state_reg == S_DIV);
  assign bus.done   = (state_reg == S_DONE);
  assign bus.result = result_reg;
  assign bus.zf     = zf_reg;
  assign bus.cf     = cf_reg;
  assign bus.vf     = vf_reg;
  assign bus.dz     = dz_reg;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl: arithmetic reference model with per-cycle compare,
// directed literal cases and randomized operations.
module tb_ula_seq_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           zf;
    logic           cf;
    logic           vf;
    logic           dz;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ula_seq_ctrl_if #(.WIDTH(W)) bus ();

  ula_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an operation must produce, straight from the arithmetic
  function automatic exp_t calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   t;
    logic [W-1:0] v;
    e = '0;
    t = '0;
    v = '0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        e.res = {{W{1'b0}}, t[W-1:0]};
        e.cf = t[W];
        e.vf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      end
      3'd1: begin
        t = {1'b0, a} - {1'b0, b};
        e.res = {{W{1'b0}}, t[W-1:0]};
        e.cf = (a < b);
        e.vf = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
      end
      3'd2: begin v = a & b; e.res = {{W{1'b0}}, v}; end
      3'd3: begin v = a | b; e.res = {{W{1'b0}}, v}; end
      3'd4: begin v = a ^ b; e.res = {{W{1'b0}}, v}; end
      3'd5: begin v = ~a;    e.res = {{W{1'b0}}, v}; end
      3'd6: e.res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: begin
        if (b == '0) begin
          e.res = {a, {W{1'b1}}};
          e.dz = 1'b1;
        end else begin
          e.res = {a % b, a / b};
        end
      end
    endcase
    e.zf = (e.res == '0);
    return e;
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
    return (op == 3'd6 || (op == 3'd7 && b != '0)) ? W : 1;
  endfunction

  // Model state: cycles left on the running op, the visible outputs, and the done pulse
  int   m_rem  = 0;
  bit   m_done = 1'b0;
  exp_t m_pend = '0;
  exp_t m_vis  = '0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_vis  <= '0;
      m_pend <= '0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_vis <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_pend <= calc(bus.op, bus.a, bus.b);
        m_rem  <= latency(bus.op, bus.b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", 32'(bus.busy), 32'(m_rem > 0));
      check("cyc done", 32'(bus.done), 32'(m_done));
      check("cyc outputs", 32'({bus.result, bus.zf, bus.cf, bus.vf, bus.dz}), 32'(m_vis));
    end
  end

  // Called at a negedge; start is sampled at the next rising edge (t0)
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic wait_done(input int poke, output int lat);
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                        input logic [3:0] exp_fl, input int exp_lat, input int poke);
    int lat;
    issue(op, a, b);
    check({name, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(poke, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, 32'(bus.result), 32'(exp_res));
    check({name, " flags"}, 32'({bus.zf, bus.cf, bus.vf, bus.dz}), 32'(exp_fl));
    $display("op=%0d a=%h b=%h -> result=%h zf=%b cf=%b vf=%b dz=%b latency=%0d",
             op, a, b, bus.result, bus.zf, bus.cf, bus.vf, bus.dz, lat);
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                          input logic [3:0] exp_fl, input int exp_lat, input int poke);
    exp_t e;
    e = calc(op, a, b);
    check({name, " model"}, 32'(e), 32'({exp_res, exp_fl}));
    run_op(name, op, a, b, exp_res, exp_fl, exp_lat, poke);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    exp_t e;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    int   rlat;

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #1 clr = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset outputs", 32'({bus.result, bus.zf, bus.cf, bus.vf, bus.dz}), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    // Chained ops: each issue lands in the previous done cycle
    directed("add ff+01", 3'd0, 8'hFF, 8'h01, 16'h0000, 4'b1100, 1, -1);
    directed("sub 80-01", 3'd1, 8'h80, 8'h01, 16'h007F, 4'b0010, 1, -1);
    directed("sub 01-02", 3'd1, 8'h01, 8'h02, 16'h00FF, 4'b0100, 1, -1);
    directed("mul 200*150 poke", 3'd6, 8'd200, 8'd150, 16'h7530, 4'b0000, 8, 2);
    directed("b2b add 5+6", 3'd0, 8'd5, 8'd6, 16'h000B, 4'b0000, 1, -1);
    directed("mul ff*ff", 3'd6, 8'hFF, 8'hFF, 16'hFE01, 4'b0000, 8, -1);
    directed("div 200/7", 3'd7, 8'd200, 8'd7, 16'h041C, 4'b0000, 8, -1);
    directed("div 35/0", 3'd7, 8'h35, 8'h00, 16'h35FF, 4'b0001, 1, -1);

    // clr in the middle of a multiply, between clock edges
    issue(3'd6, 8'd200, 8'd150);
    repeat (4) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr busy", 32'(bus.busy), 32'd0);
    check("clr done", 32'(bus.done), 32'd0);
    check("clr outputs", 32'({bus.result, bus.zf, bus.cf, bus.vf, bus.dz}), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("clr no done", 32'(seen), 32'd0);
    $display("clr mid-mul -> done pulses after release=%0d", seen);
    directed("add 3+4", 3'd0, 8'd3, 8'd4, 16'h0007, 4'b0000, 1, -1);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      e   = calc(rop, ra, rb);
      rlat = latency(rop, rb);
      run_op("rand", rop, ra, rb, e.res, {e.zf, e.cf, e.vf, e.dz}, rlat,
             (rlat == W) ? int'($urandom_range(0, W - 2)) : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
